book_level_updater: RTL and testbench

Initiator-side controller for the order-book BRAM memory manager. It accepts one price-level command at a time (read, add quantity, subtract quantity, or set), then drives the memory manager's start/is_write/addr/data request port. It waits for the manager's `valid` pulse and performs read-modify-write where needed. It returns the resulting `book_entry` on a one-cycle response strobe. It sits between the order-message decoder and `memory_manager`.

---
 rtl/book_level_updater_pkg.sv | 29 ++
 rtl/book_level_updater_qty_alu.sv | 42 ++++
 rtl/book_level_updater.sv | 168 ++++++++++++++++
 tb/tb_book_level_updater.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/book_level_updater_pkg.sv
// Shared order-book types: the packed level entry, the command encoding and
// the controller state encoding used by book_level_updater.
package book_level_updater_pkg;

   localparam int ADDRESS_INDEX = 9;
   localparam int BRAM_LATENCY  = 2;

   typedef struct packed {
      logic [31:0] price;
      logic [31:0] quantity;
   } book_entry;

   typedef enum logic [1:0] {
      OP_READ = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2,
      OP_SET  = 2'd3
   } book_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_RESP
   } upd_state_e;

endpackage

// File: rtl/book_level_updater_qty_alu.sv
// Combinational saturating quantity update: ADD clamps at all-ones, SUB clamps
// at zero, anything else passes the operand through unchanged.
module book_qty_alu
   import book_level_updater_pkg::*;
(
   input  book_op_e    i_op,
   input  logic [31:0] i_stored_qty,
   input  logic [31:0] i_operand,
   output logic [31:0] o_qty,
   output logic        o_sat
);

   logic [32:0] w_sum;

   assign w_sum = {1'b0, i_stored_qty} + {1'b0, i_operand};

   // NOTE: both outputs get a default before the case so no path can infer a latch.
   always_comb begin
      o_qty = i_operand;
      o_sat = 1'b0;
      case (i_op)
         OP_ADD: begin
            if (w_sum[32]) begin
               o_qty = '1;
               o_sat = 1'b1;
            end else begin
               o_qty = w_sum[31:0];
            end
         end
         OP_SUB: begin
            if (i_operand > i_stored_qty) begin
               o_qty = '0;
               o_sat = 1'b1;
            end else begin
               o_qty = i_stored_qty - i_operand;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/book_level_updater.sv
// Single-command price-level controller: read / read-modify-write / write
// through the BRAM memory manager, with a bounded wait on each access.
module book_level_updater
   import book_level_updater_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [ADDRESS_INDEX:0] req_addr,
   input  logic [31:0]            req_price,
   input  logic [31:0]            req_qty,
   output logic                   mem_start,
   output logic                   mem_is_write,
   output logic [ADDRESS_INDEX:0] mem_addr,
   output book_entry              mem_wdata,
   input  book_entry              mem_rdata,
   input  logic                   mem_valid,
   output logic                   rsp_valid,
   output book_entry              rsp_entry,
   output logic                   rsp_sat,
   output logic                   rsp_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   upd_state_e             r_state;
   book_op_e               r_op;
   logic [31:0]            r_qty;
   logic                   r_sat;
   logic [CNT_W-1:0]       r_wait_cnt;
   logic                   r_req_ready;
   logic                   r_mem_start;
   logic                   r_mem_is_write;
   logic [ADDRESS_INDEX:0] r_mem_addr;
   book_entry              r_mem_wdata;
   logic                   r_rsp_valid;
   book_entry              r_rsp_entry;
   logic                   r_rsp_sat;
   logic                   r_rsp_error;

   logic [31:0]            w_new_qty;
   logic                   w_sat;
   logic                   w_timeout;

   book_qty_alu u_alu (
      .i_op         (r_op),
      .i_stored_qty (mem_rdata.quantity),
      .i_operand    (r_qty),
      .o_qty        (w_new_qty),
      .o_sat        (w_sat)
   );

   // The wait counter runs 0..TIMEOUT_CYCLES-1 across the wait states.
   assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // NOTE: sequential state uses non-blocking assignments; pulse outputs default low each cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state        <= ST_IDLE;
         r_op           <= OP_READ;
         r_qty          <= '0;
         r_sat          <= 1'b0;
         r_wait_cnt     <= '0;
         r_req_ready    <= 1'b1;
         r_mem_start    <= 1'b0;
         r_mem_is_write <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_entry    <= '0;
         r_rsp_sat      <= 1'b0;
         r_rsp_error    <= 1'b0;
      end else begin
         r_mem_start <= 1'b0;
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_op        <= book_op_e'(req_op);
                  r_qty       <= req_qty;
                  r_sat       <= 1'b0;
                  r_mem_addr  <= req_addr;
                  r_req_ready <= 1'b0;
                  r_mem_start <= 1'b1;
                  if (book_op_e'(req_op) == OP_SET) begin
                     r_mem_is_write <= 1'b1;
                     r_mem_wdata    <= '{price: req_price, quantity: req_qty};
                     r_state        <= ST_WR_REQ;
                  end else begin
                     r_mem_is_write <= 1'b0;
                     r_state        <= ST_RD_REQ;
                  end
               end
            end
            ST_RD_REQ: begin
               r_wait_cnt <= '0;
               r_state    <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (mem_valid) begin
                  if (r_op == OP_READ) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_entry <= mem_rdata;
                     r_rsp_sat   <= 1'b0;
                     r_rsp_error <= 1'b0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_mem_wdata    <= '{price: mem_rdata.price, quantity: w_new_qty};
                     r_sat          <= w_sat;
                     r_mem_is_write <= 1'b1;
                     r_mem_start    <= 1'b1;
                     r_state        <= ST_WR_REQ;
                  end
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_entry <= '0;
                  r_rsp_sat   <= 1'b0;
                  r_rsp_error <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_WR_REQ: begin
               r_wait_cnt <= '0;
               r_state    <= ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
               if (mem_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_entry <= r_mem_wdata;
                  r_rsp_sat   <= r_sat;
                  r_rsp_error <= 1'b0;
                  r_state     <= ST_RESP;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_entry <= '0;
                  r_rsp_sat   <= 1'b0;
                  r_rsp_error <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_req_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = r_req_ready;
   assign mem_start    = r_mem_start;
   assign mem_is_write = r_mem_is_write;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_entry    = r_rsp_entry;
   assign rsp_sat      = r_rsp_sat;
   assign rsp_error    = r_rsp_error;

endmodule

// File: tb/tb_book_level_updater.sv
// Directed bench for book_level_updater with a behavioural fixed-latency BRAM
// responder that can drop completions or inject stray ones.
module tb_book_level_updater;
   import book_level_updater_pkg::*;

   localparam int M       = BRAM_LATENCY;
   localparam int TMO     = 16;
   localparam int AW      = ADDRESS_INDEX + 1;
   localparam int LAT_RS  = M + 3;
   localparam int LAT_RMW = 2 * M + 5;
   localparam int LAT_TMO = TMO + 2;
   localparam int NV      = 15;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_price;
   logic [31:0]   req_qty;
   logic          mem_start;
   logic          mem_is_write;
   logic [AW-1:0] mem_addr;
   book_entry     mem_wdata;
   book_entry     mem_rdata;
   logic          mem_valid;
   logic          rsp_valid;
   book_entry     rsp_entry;
   logic          rsp_sat;
   logic          rsp_error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_in = ~clk_in;

   book_level_updater #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_price    (req_price),
      .req_qty      (req_qty),
      .mem_start    (mem_start),
      .mem_is_write (mem_is_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_valid    (mem_valid),
      .rsp_valid    (rsp_valid),
      .rsp_entry    (rsp_entry),
      .rsp_sat      (rsp_sat),
      .rsp_error    (rsp_error)
   );

   // Responder: mem_valid lands M+1 cycles after the mem_start cycle; not reset.
   book_entry     mem_model [0:(1<<AW)-1];
   logic          r_busy    = 1'b0;
   int            r_cnt     = 0;
   logic          lat_we    = 1'b0;
   logic [AW-1:0] lat_addr  = '0;
   book_entry     lat_wdata = '0;
   logic          q_valid   = 1'b0;
   logic          rsp_drop  = 1'b0;
   logic          inj_valid = 1'b0;

   assign mem_valid = q_valid | inj_valid;

   always @(posedge clk_in) begin
      q_valid <= 1'b0;
      if (r_busy) begin
         if (r_cnt == 1) begin
            r_busy <= 1'b0;
            if (!rsp_drop) begin
               q_valid <= 1'b1;
               if (lat_we) mem_model[lat_addr] <= lat_wdata;
               else        mem_rdata <= mem_model[lat_addr];
            end
         end else begin
            r_cnt <= r_cnt - 1;
         end
      end else if (mem_start) begin
         r_busy    <= 1'b1;
         r_cnt     <= M;
         lat_we    <= mem_is_write;
         lat_addr  <= mem_addr;
         lat_wdata <= mem_wdata;
      end
   end

   // Bus monitor, sampled on the falling edge.
   int            cyc = 0;
   int            n_start = 0, n_valid = 0, n_rsp = 0, n_overlap = 0, n_unstable = 0;
   logic          outstanding = 1'b0;
   logic [AW-1:0] hold_addr;
   logic          hold_we;
   book_entry     hold_wdata;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (mem_start) begin
         n_start++;
         if (mem_valid || outstanding) n_overlap++;
         outstanding = 1'b1;
         hold_addr   = mem_addr;
         hold_we     = mem_is_write;
         hold_wdata  = mem_wdata;
      end else if (outstanding && !rst_in) begin
         if ({mem_addr, mem_is_write, mem_wdata} !== {hold_addr, hold_we, hold_wdata}) n_unstable++;
      end
      if (mem_valid) n_valid++;
      if (rsp_valid) n_rsp++;
      if (mem_valid || rsp_valid || rst_in) outstanding = 1'b0;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [31:0] price, input logic [31:0] qty,
                          output book_entry e, output logic sat, output logic err,
                          output int lat, output int starts);
      int acc, s0, g;
      @(negedge clk_in);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_price = price;
      req_qty   = qty;
      g = 0;
      while (!req_ready && g < 200) begin
         @(negedge clk_in);
         g++;
      end
      acc = cyc;
      s0  = n_start;
      @(negedge clk_in);
      req_valid = 1'b0;
      g = 0;
      while (!rsp_valid && g < 200) begin
         @(negedge clk_in);
         g++;
      end
      e      = rsp_entry;
      sat    = rsp_sat;
      err    = rsp_error;
      lat    = rsp_valid ? cyc - acc : -1;
      starts = n_start - s0;
   endtask

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [31:0]   price;
      logic [31:0]   qty;
      logic [31:0]   exp_price;
      logic [31:0]   exp_qty;
      logic          exp_sat;
      int            exp_lat;
      int            exp_starts;
   } vec_t;

   vec_t vecs [NV];

   book_entry     e;
   logic          sat, err;
   int            lat, starts;
   int            a, s0, r0, v0, gd, gc;
   logic [AW-1:0] amax;
   int            acc_c [3];
   int            rsp_c [3];
   book_entry     got_e [3];
   logic          got_s [3];
   logic [1:0]    c_op  [3];
   logic [31:0]   c_qty [3];
   logic [31:0]   c_exp [3];

   initial begin
      amax = '1;
      vecs[0]  = '{OP_SET,  AW'(5), 32'd100,       32'd40,          32'd100, 32'd40,          1'b0, LAT_RS,  1};
      vecs[1]  = '{OP_READ, AW'(5), 32'hDEAD_BEEF, 32'd0,           32'd100, 32'd40,          1'b0, LAT_RS,  1};
      vecs[2]  = '{OP_ADD,  AW'(5), 32'hDEAD_BEEF, 32'd25,          32'd100, 32'd65,          1'b0, LAT_RMW, 2};
      vecs[3]  = '{OP_READ, AW'(5), 32'hDEAD_BEEF, 32'd0,           32'd100, 32'd65,          1'b0, LAT_RS,  1};
      vecs[4]  = '{OP_SUB,  AW'(5), 32'hDEAD_BEEF, 32'd70,          32'd100, 32'd0,           1'b1, LAT_RMW, 2};
      vecs[5]  = '{OP_SET,  AW'(7), 32'd200,       32'hFFFF_FFFF,   32'd200, 32'hFFFF_FFFF,   1'b0, LAT_RS,  1};
      vecs[6]  = '{OP_ADD,  AW'(7), 32'hDEAD_BEEF, 32'd1,           32'd200, 32'hFFFF_FFFF,   1'b1, LAT_RMW, 2};
      vecs[7]  = '{OP_SUB,  AW'(7), 32'hDEAD_BEEF, 32'd5,           32'd200, 32'hFFFF_FFFA,   1'b0, LAT_RMW, 2};
      vecs[8]  = '{OP_ADD,  AW'(7), 32'hDEAD_BEEF, 32'd3,           32'd200, 32'hFFFF_FFFD,   1'b0, LAT_RMW, 2};
      vecs[9]  = '{OP_SUB,  AW'(7), 32'hDEAD_BEEF, 32'hFFFF_FFFD,   32'd200, 32'd0,           1'b0, LAT_RMW, 2};
      vecs[10] = '{OP_ADD,  AW'(7), 32'hDEAD_BEEF, 32'hFFFF_FFFF,   32'd200, 32'hFFFF_FFFF,   1'b0, LAT_RMW, 2};
      vecs[11] = '{OP_SET,  AW'(0), 32'd1,         32'd2,           32'd1,   32'd2,           1'b0, LAT_RS,  1};
      vecs[12] = '{OP_SET,  amax,   32'd9,         32'd3,           32'd9,   32'd3,           1'b0, LAT_RS,  1};
      vecs[13] = '{OP_READ, AW'(0), 32'hDEAD_BEEF, 32'd0,           32'd1,   32'd2,           1'b0, LAT_RS,  1};
      vecs[14] = '{OP_READ, amax,   32'hDEAD_BEEF, 32'd0,           32'd9,   32'd3,           1'b0, LAT_RS,  1};

      rst_in    = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_addr  = '0;
      req_price = '0;
      req_qty   = '0;
      repeat (3) @(negedge clk_in);
      check("rst req_ready",    req_ready,    1);
      check("rst mem_start",    mem_start,    0);
      check("rst mem_is_write", mem_is_write, 0);
      check("rst mem_addr",     mem_addr,     0);
      check("rst mem_wdata",    mem_wdata,    0);
      check("rst rsp_valid",    rsp_valid,    0);
      check("rst rsp_entry",    rsp_entry,    0);
      check("rst rsp_sat",      rsp_sat,      0);
      check("rst rsp_error",    rsp_error,    0);
      rst_in = 1'b0;

      // Stray completion while idle.
      @(negedge clk_in);
      inj_valid = 1'b1;
      @(negedge clk_in);
      inj_valid = 1'b0;
      repeat (3) @(negedge clk_in);
      check("stray rsp count",  n_rsp,     0);
      check("stray start count", n_start,  0);
      check("stray req_ready",  req_ready, 1);

      for (int i = 0; i < NV; i++) begin
         run_cmd(vecs[i].op, vecs[i].addr, vecs[i].price, vecs[i].qty, e, sat, err, lat, starts);
         check($sformatf("vec%0d entry", i),  e,      {vecs[i].exp_price, vecs[i].exp_qty});
         check($sformatf("vec%0d sat", i),    sat,    vecs[i].exp_sat);
         check($sformatf("vec%0d error", i),  err,    0);
         check($sformatf("vec%0d latency", i), lat,   vecs[i].exp_lat);
         check($sformatf("vec%0d starts", i), starts, vecs[i].exp_starts);
      end

      // Dropped completions: read, read-modify-write and write all time out.
      rsp_drop = 1'b1;
      run_cmd(OP_READ, AW'(5), 32'd0, 32'd0, e, sat, err, lat, starts);
      check("tmo read error",   err,    1);
      check("tmo read entry",   e,      0);
      check("tmo read latency", lat,    LAT_TMO);
      check("tmo read starts",  starts, 1);
      run_cmd(OP_ADD, AW'(5), 32'd0, 32'd1, e, sat, err, lat, starts);
      check("tmo add error",    err,    1);
      check("tmo add sat",      sat,    0);
      check("tmo add latency",  lat,    LAT_TMO);
      check("tmo add no write", starts, 1);
      run_cmd(OP_SET, AW'(9), 32'd5, 32'd6, e, sat, err, lat, starts);
      check("tmo set error",    err,    1);
      check("tmo set latency",  lat,    LAT_TMO);
      rsp_drop = 1'b0;
      run_cmd(OP_READ, AW'(5), 32'd0, 32'd0, e, sat, err, lat, starts);
      check("post-tmo entry",   e,      {32'd100, 32'd0});
      check("post-tmo error",   err,    0);
      check("post-tmo latency", lat,    LAT_RS);

      // Reset during the read wait of an ADD; the late completion must be ignored.
      @(negedge clk_in);
      req_valid = 1'b1;
      req_op    = OP_ADD;
      req_addr  = AW'(5);
      req_qty   = 32'd7;
      a = cyc;
      @(negedge clk_in);
      req_valid = 1'b0;
      check("rstmid start", mem_start, 1);
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      check("rstmid req_ready", req_ready, 1);
      check("rstmid mem_start", mem_start, 0);
      check("rstmid mem_addr",  mem_addr,  0);
      check("rstmid mem_wdata", mem_wdata, 0);
      s0 = n_start;
      r0 = n_rsp;
      v0 = n_valid;
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (8) @(negedge clk_in);
      check("rstmid late valid seen", n_valid - v0, 1);
      check("rstmid no response",     n_rsp - r0,   0);
      check("rstmid no new start",    n_start - s0, 0);
      check("rstmid req_ready after", req_ready,    1);
      run_cmd(OP_READ, AW'(5), 32'd0, 32'd0, e, sat, err, lat, starts);
      check("rstmid entry unchanged", e, {32'd100, 32'd0});

      // Three commands with req_valid held high throughout.
      c_op[0] = OP_ADD;  c_qty[0] = 32'd10; c_exp[0] = 32'd10;
      c_op[1] = OP_SUB;  c_qty[1] = 32'd4;  c_exp[1] = 32'd6;
      c_op[2] = OP_READ; c_qty[2] = 32'd0;  c_exp[2] = 32'd6;
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk_in);
               req_valid = 1'b1;
               req_op    = c_op[i];
               req_addr  = AW'(5);
               req_price = 32'hDEAD_BEEF;
               req_qty   = c_qty[i];
               gd = 0;
               while (!req_ready && gd < 300) begin
                  @(negedge clk_in);
                  gd++;
               end
               acc_c[i] = cyc;
            end
            @(negedge clk_in);
            req_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 3; i++) begin
               gc = 0;
               do begin
                  @(negedge clk_in);
                  gc++;
               end while (!rsp_valid && gc < 300);
               rsp_c[i] = rsp_valid ? cyc : -1;
               got_e[i] = rsp_entry;
               got_s[i] = rsp_sat;
            end
         end
      join
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b%0d entry", i), got_e[i], {32'd100, c_exp[i]});
         check($sformatf("b2b%0d sat", i),   got_s[i], 0);
         if (i > 0) check($sformatf("b2b%0d accept after rsp", i), acc_c[i], rsp_c[i-1] + 1);
      end
      check("b2b read latency", rsp_c[2] - acc_c[2], LAT_RS);

      check("no start/valid overlap", n_overlap,  0);
      check("request held stable",    n_unstable, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
